// File: rtl/rename_pkg.sv
// Shared rename types: logical register index, ROB tag and the source mapping
// record handed from rename to register read.
package rename_pkg;

  localparam int NREG   = 32;
  localparam int ROB_W  = 6;
  localparam int LREG_W = $clog2(NREG);

  typedef logic [LREG_W-1:0] logic_reg_t;
  typedef logic [ROB_W-1:0]  rob_tag_t;

  typedef struct packed {
    logic     rob;
    rob_tag_t tag;
  } src_map_t;

  // One-hot select of a logical register; register 0 is never selected.
  function automatic logic [NREG-1:0] reg_onehot(logic_reg_t idx, logic en);
    logic [NREG-1:0] v;
    v = '0;
    if (en && (idx != '0)) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/srat_tag_if.sv
// Rename-group, commit and control signals of the speculative rename tag table.
interface srat_tag_if;
  import rename_pkg::*;

  logic       stall_RNR;
  logic       stall_RR;
  logic       recover;

  logic_reg_t rs1l, rt1l, rs2l, rt2l;
  logic_reg_t rd1l, rd2l;
  logic       rd1_en, rd2_en;
  rob_tag_t   rob1_tag, rob2_tag;

  rob_tag_t   rs1_tag, rt1_tag, rs2_tag, rt2_tag;
  logic       rs1_rob, rt1_rob, rs2_rob, rt2_rob;

  logic_reg_t rd1l_c, rd2l_c;
  logic       rd1_enc_in, rd2_enc_in;
  rob_tag_t   rob1_tag_c, rob2_tag_c;
  logic       rd1_enc, rd2_enc;

  modport master (
    output stall_RNR, stall_RR, recover,
    output rs1l, rt1l, rs2l, rt2l, rd1l, rd2l, rd1_en, rd2_en, rob1_tag, rob2_tag,
    output rd1l_c, rd2l_c, rd1_enc_in, rd2_enc_in, rob1_tag_c, rob2_tag_c,
    input  rs1_tag, rt1_tag, rs2_tag, rt2_tag, rs1_rob, rt1_rob, rs2_rob, rt2_rob,
    input  rd1_enc, rd2_enc
  );

  modport slave (
    input  stall_RNR, stall_RR, recover,
    input  rs1l, rt1l, rs2l, rt2l, rd1l, rd2l, rd1_en, rd2_en, rob1_tag, rob2_tag,
    input  rd1l_c, rd2l_c, rd1_enc_in, rd2_enc_in, rob1_tag_c, rob2_tag_c,
    output rs1_tag, rt1_tag, rs2_tag, rt2_tag, rs1_rob, rt1_rob, rs2_rob, rt2_rob,
    output rd1_enc, rd2_enc
  );

endinterface

// File: rtl/srat_tag_lookup.sv
// Combinational 4-port source read of the rename tag table with the
// instr1->instr2 intra-group bypass and register-0 masking.
module srat_tag_lookup
  import rename_pkg::*;
(
  input  rob_tag_t [NREG-1:0] tag,
  input  logic [NREG-1:0]     live,
  input  logic_reg_t          rs1l,
  input  logic_reg_t          rt1l,
  input  logic_reg_t          rs2l,
  input  logic_reg_t          rt2l,
  input  logic_reg_t          rd1l,
  input  logic                rd1_en,
  input  rob_tag_t            rob1_tag,
  output src_map_t            rs1_map,
  output src_map_t            rt1_map,
  output src_map_t            rs2_map,
  output src_map_t            rt2_map
);

  src_map_t bypass_map;

  // Instr2 sources see instr1's destination from the same group; r0 reads as ARF.
  always_comb begin
    bypass_map = '{rob: 1'b1, tag: rob1_tag};

    rs1_map = '{rob: live[rs1l], tag: tag[rs1l]};
    rt1_map = '{rob: live[rt1l], tag: tag[rt1l]};
    rs2_map = '{rob: live[rs2l], tag: tag[rs2l]};
    rt2_map = '{rob: live[rt2l], tag: tag[rt2l]};

    if (rd1_en && (rs2l == rd1l)) rs2_map = bypass_map;
    if (rd1_en && (rt2l == rd1l)) rt2_map = bypass_map;

    if (rs1l == '0) rs1_map = '0;
    if (rt1l == '0) rt1_map = '0;
    if (rs2l == '0) rs2_map = '0;
    if (rt2l == '0) rt2_map = '0;
  end

endmodule

// File: rtl/srat_tag.sv
// Speculative rename tag table: youngest in-flight ROB writer per logical
// register, registered source tags for RR and commit-time latest-mapping test.
module srat_tag
  import rename_pkg::*;
(
  input logic       clk,
  input logic       rst,
  srat_tag_if.slave bus
);

  rob_tag_t [NREG-1:0] tag_q, tag_d;
  logic [NREG-1:0]     live_q, live_d;
  logic [NREG-1:0]     wr1, wr2, clr;

  src_map_t rs1_map, rt1_map, rs2_map, rt2_map;
  src_map_t rs1_q, rt1_q, rs2_q, rt2_q;

  logic rd1_hit, rd2_hit;

  srat_tag_lookup u_lookup (
    .tag      (tag_q),
    .live     (live_q),
    .rs1l     (bus.rs1l),
    .rt1l     (bus.rt1l),
    .rs2l     (bus.rs2l),
    .rt2l     (bus.rt2l),
    .rd1l     (bus.rd1l),
    .rd1_en   (bus.rd1_en),
    .rob1_tag (bus.rob1_tag),
    .rs1_map  (rs1_map),
    .rt1_map  (rt1_map),
    .rs2_map  (rs2_map),
    .rt2_map  (rt2_map)
  );

  // A same-index instr2 commit retires the younger writer, so instr1 must not update.
  always_comb begin
    rd2_hit = bus.rd2_enc_in && live_q[bus.rd2l_c] &&
              (tag_q[bus.rd2l_c] == bus.rob2_tag_c);
    rd1_hit = bus.rd1_enc_in && live_q[bus.rd1l_c] &&
              (tag_q[bus.rd1l_c] == bus.rob1_tag_c) &&
              !(bus.rd2_enc_in && (bus.rd2l_c == bus.rd1l_c));
    if (bus.recover) begin
      rd1_hit = 1'b0;
      rd2_hit = 1'b0;
    end
  end

  assign bus.rd1_enc = rd1_hit;
  assign bus.rd2_enc = rd2_hit;

  // Renames override commit clears on the same index; instr2 overrides instr1.
  always_comb begin
    wr1    = reg_onehot(bus.rd1l, bus.rd1_en && !bus.stall_RNR);
    wr2    = reg_onehot(bus.rd2l, bus.rd2_en && !bus.stall_RNR);
    clr    = reg_onehot(bus.rd1l_c, rd1_hit) | reg_onehot(bus.rd2l_c, rd2_hit);
    live_d = (live_q & ~clr) | wr1 | wr2;
    tag_d  = tag_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr1[i]) tag_d[i] = bus.rob1_tag;
      if (wr2[i]) tag_d[i] = bus.rob2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q <= '0;
      tag_q  <= '0;
    end else if (bus.recover) begin
      live_q <= '0;
    end else begin
      live_q <= live_d;
      tag_q  <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.recover) begin
      rs1_q <= '0;
      rt1_q <= '0;
      rs2_q <= '0;
      rt2_q <= '0;
    end else if (!bus.stall_RR) begin
      rs1_q <= rs1_map;
      rt1_q <= rt1_map;
      rs2_q <= rs2_map;
      rt2_q <= rt2_map;
    end
  end

  assign bus.rs1_tag = rs1_q.tag;
  assign bus.rt1_tag = rt1_q.tag;
  assign bus.rs2_tag = rs2_q.tag;
  assign bus.rt2_tag = rt2_q.tag;
  assign bus.rs1_rob = rs1_q.rob;
  assign bus.rt1_rob = rt1_q.rob;
  assign bus.rs2_rob = rs2_q.rob;
  assign bus.rt2_rob = rt2_q.rob;

endmodule

// File: tb/tb_srat_tag.sv
// Scoreboard bench for srat_tag: directed rename/commit/recover sequences then
// randomized groups, checked against an array-based model of the table.
module tb_srat_tag;
  import rename_pkg::*;

  typedef struct {
    bit       rst;
    bit       recover;
    bit       stall_RNR;
    bit       stall_RR;
    bit [4:0] rs1l, rt1l, rs2l, rt2l, rd1l, rd2l;
    bit       rd1_en, rd2_en;
    bit [5:0] rob1_tag, rob2_tag;
    bit [4:0] rd1l_c, rd2l_c;
    bit       rd1_enc_in, rd2_enc_in;
    bit [5:0] rob1_tag_c, rob2_tag_c;
  } stim_t;

  typedef src_map_t [3:0] src_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  srat_tag_if bus ();

  srat_tag dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  bit [5:0] ref_tag  [NREG];
  bit       ref_live [NREG];
  src_vec_t held_src = '0;

  src_vec_t  src_q [$];
  bit [1:0]  enc_q [$];

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic src_map_t model_read(int idx, bit is_instr2, stim_t s);
    src_map_t r;
    r.rob = ref_live[idx];
    r.tag = ref_tag[idx];
    if (is_instr2 && s.rd1_en && (idx == int'(s.rd1l))) begin
      r.rob = 1'b1;
      r.tag = s.rob1_tag;
    end
    if (idx == 0) r = '0;
    return r;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    s.rst = 1'b1;
    return s;
  endfunction

  // Drive one group at the falling edge, queue its expected responses, advance the model.
  task automatic apply_stimulus(input stim_t s);
    bit e1, e2;
    @(negedge clk);
    rst            = s.rst;
    bus.recover    = s.recover;
    bus.stall_RNR  = s.stall_RNR;
    bus.stall_RR   = s.stall_RR;
    bus.rs1l       = s.rs1l;
    bus.rt1l       = s.rt1l;
    bus.rs2l       = s.rs2l;
    bus.rt2l       = s.rt2l;
    bus.rd1l       = s.rd1l;
    bus.rd2l       = s.rd2l;
    bus.rd1_en     = s.rd1_en;
    bus.rd2_en     = s.rd2_en;
    bus.rob1_tag   = s.rob1_tag;
    bus.rob2_tag   = s.rob2_tag;
    bus.rd1l_c     = s.rd1l_c;
    bus.rd2l_c     = s.rd2l_c;
    bus.rd1_enc_in = s.rd1_enc_in;
    bus.rd2_enc_in = s.rd2_enc_in;
    bus.rob1_tag_c = s.rob1_tag_c;
    bus.rob2_tag_c = s.rob2_tag_c;
    #1;

    e2 = s.rd2_enc_in && ref_live[s.rd2l_c] && (ref_tag[s.rd2l_c] == s.rob2_tag_c);
    e1 = s.rd1_enc_in && ref_live[s.rd1l_c] && (ref_tag[s.rd1l_c] == s.rob1_tag_c) &&
         !(s.rd2_enc_in && (s.rd2l_c == s.rd1l_c));
    if (s.recover) begin
      e1 = 1'b0;
      e2 = 1'b0;
    end
    enc_q.push_back({e1, e2});

    if (!s.rst || s.recover) begin
      held_src = '0;
    end else if (!s.stall_RR) begin
      held_src[0] = model_read(int'(s.rs1l), 1'b0, s);
      held_src[1] = model_read(int'(s.rt1l), 1'b0, s);
      held_src[2] = model_read(int'(s.rs2l), 1'b1, s);
      held_src[3] = model_read(int'(s.rt2l), 1'b1, s);
    end
    src_q.push_back(held_src);

    if (!s.rst) begin
      for (int i = 0; i < NREG; i++) begin
        ref_live[i] = 1'b0;
        ref_tag[i]  = '0;
      end
    end else if (s.recover) begin
      for (int i = 0; i < NREG; i++) ref_live[i] = 1'b0;
    end else begin
      if (e1) ref_live[s.rd1l_c] = 1'b0;
      if (e2) ref_live[s.rd2l_c] = 1'b0;
      if (!s.stall_RNR) begin
        if (s.rd1_en && s.rd1l != 0) begin
          ref_tag[s.rd1l]  = s.rob1_tag;
          ref_live[s.rd1l] = 1'b1;
        end
        if (s.rd2_en && s.rd2l != 0) begin
          ref_tag[s.rd2l]  = s.rob2_tag;
          ref_live[s.rd2l] = 1'b1;
        end
      end
    end
  endtask

  initial begin : enc_monitor
    bit [1:0] exp_enc;
    forever begin
      @(negedge clk);
      #3;
      if (enc_q.size() > 0) begin
        exp_enc = enc_q.pop_front();
        check_output("rd1_enc", {7'b0, bus.rd1_enc}, {7'b0, exp_enc[1]});
        check_output("rd2_enc", {7'b0, bus.rd2_enc}, {7'b0, exp_enc[0]});
      end
    end
  end

  initial begin : src_monitor
    src_vec_t exp_src;
    forever begin
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        exp_src = src_q.pop_front();
        check_output("rs1_rob", {7'b0, bus.rs1_rob}, {7'b0, exp_src[0].rob});
        check_output("rs1_tag", {2'b0, bus.rs1_tag}, {2'b0, exp_src[0].tag});
        check_output("rt1_rob", {7'b0, bus.rt1_rob}, {7'b0, exp_src[1].rob});
        check_output("rt1_tag", {2'b0, bus.rt1_tag}, {2'b0, exp_src[1].tag});
        check_output("rs2_rob", {7'b0, bus.rs2_rob}, {7'b0, exp_src[2].rob});
        check_output("rs2_tag", {2'b0, bus.rs2_tag}, {2'b0, exp_src[2].tag});
        check_output("rt2_rob", {7'b0, bus.rt2_rob}, {7'b0, exp_src[3].rob});
        check_output("rt2_tag", {2'b0, bus.rt2_tag}, {2'b0, exp_src[3].tag});
      end
    end
  end

  initial begin : stimulus
    stim_t s;

    s = idle_stim();
    s.rst = 1'b0;
    apply_stimulus(s);
    apply_stimulus(s);

    s = idle_stim(); s.rs1l = 5;
    apply_stimulus(s);

    s = idle_stim();
    s.rd1_en = 1; s.rd1l = 3; s.rob1_tag = 10;
    s.rd2_en = 1; s.rd2l = 3; s.rob2_tag = 11;
    apply_stimulus(s);

    s = idle_stim(); s.rs1l = 3;
    apply_stimulus(s);

    s = idle_stim();
    s.rd1_en = 1; s.rd1l = 7; s.rob1_tag = 4; s.rs2l = 7; s.rs1l = 7;
    apply_stimulus(s);

    s = idle_stim(); s.rd1_enc_in = 1; s.rd1l_c = 3; s.rob1_tag_c = 10; s.rs1l = 3;
    apply_stimulus(s);
    s.rob1_tag_c = 11;
    apply_stimulus(s);
    s = idle_stim(); s.rs1l = 3;
    apply_stimulus(s);

    s = idle_stim(); s.rd1_en = 1; s.rd1l = 3; s.rob1_tag = 11;
    apply_stimulus(s);
    s = idle_stim();
    s.rd1_enc_in = 1; s.rd1l_c = 3; s.rob1_tag_c = 11;
    s.rd1_en = 1; s.rd1l = 3; s.rob1_tag = 12;
    apply_stimulus(s);
    s = idle_stim(); s.rs1l = 3;
    apply_stimulus(s);

    s = idle_stim(); s.rd2_en = 1; s.rd2l = 9; s.rob2_tag = 20;
    apply_stimulus(s);
    s = idle_stim();
    s.rd1_enc_in = 1; s.rd1l_c = 9; s.rob1_tag_c = 20;
    s.rd2_enc_in = 1; s.rd2l_c = 9; s.rob2_tag_c = 20;
    apply_stimulus(s);

    s = idle_stim(); s.rd1_en = 1; s.rd1l = 5; s.rob1_tag = 33;
    apply_stimulus(s);
    s = idle_stim(); s.recover = 1; s.rd1_en = 1; s.rd1l = 4; s.rob1_tag = 40;
    s.rs1l = 5; s.rd1_enc_in = 1; s.rd1l_c = 5; s.rob1_tag_c = 33;
    apply_stimulus(s);
    s = idle_stim(); s.rs1l = 4; s.rt1l = 5; s.rs2l = 3; s.rt2l = 7;
    apply_stimulus(s);

    for (int n = 0; n < 400; n++) begin
      s = idle_stim();
      s.rst        = ($urandom_range(0, 99) != 0);
      s.recover    = ($urandom_range(0, 31) == 0);
      s.stall_RNR  = ($urandom_range(0, 7) == 0);
      s.stall_RR   = ($urandom_range(0, 7) == 0);
      s.rs1l       = 5'($urandom_range(0, 9));
      s.rt1l       = 5'($urandom_range(0, 9));
      s.rs2l       = 5'($urandom_range(0, 9));
      s.rt2l       = 5'($urandom_range(0, 31));
      s.rd1l       = 5'($urandom_range(0, 9));
      s.rd2l       = 5'($urandom_range(0, 9));
      s.rd1_en     = 1'($urandom_range(0, 1));
      s.rd2_en     = 1'($urandom_range(0, 1));
      s.rob1_tag   = 6'($urandom_range(0, 63));
      s.rob2_tag   = 6'($urandom_range(0, 63));
      s.rd1l_c     = 5'($urandom_range(0, 9));
      s.rd2l_c     = 5'($urandom_range(0, 9));
      s.rd1_enc_in = 1'($urandom_range(0, 1));
      s.rd2_enc_in = 1'($urandom_range(0, 1));
      s.rob1_tag_c = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : ref_tag[s.rd1l_c];
      s.rob2_tag_c = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : ref_tag[s.rd2l_c];
      apply_stimulus(s);
    end

    apply_stimulus(idle_stim());
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/srat_tag.md
# srat_tag

Speculative rename tag table for the dual-issue out-of-order core: for each of the 32 logical registers it records the ROB tag of the youngest in-flight writer, plus a live bit. It is written at rename (RNR) and provides source tags to register read (RR). At commit it decides whether each retiring destination is still the latest mapping, and drives the `rd1_enc`/`rd2_enc` enables consumed by the ARF/ROB location table (`srat_1`).

## Interface
- `ROB_W`, 6: ROB tag width (64-entry ROB).
- `NREG`, 32: logical register count; logical index width is 5.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `stall_RNR` in 1: freeze rename writes.
- `stall_RR` in 1: hold registered source outputs.
- `recover` in 1: flush; all mappings revert to ARF.
- `rs1l`, `rt1l`, `rs2l`, `rt2l` in 5 each: source logical numbers of rename group (instr1, instr2).
- `rd1l`, `rd2l` in 5 each: destination logical numbers.
- `rd1_en`, `rd2_en` in 1 each: destination write enables.
- `rob1_tag`, `rob2_tag` in ROB_W each: ROB tags allocated to instr1/instr2.
- `rs1_tag`, `rt1_tag`, `rs2_tag`, `rt2_tag` out ROB_W each: registered source tags for RR.
- `rs1_rob`, `rt1_rob`, `rs2_rob`, `rt2_rob` out 1 each: registered; 1 = operand produced by in-flight ROB entry, 0 = read ARF.
- `rd1l_c`, `rd2l_c` in 5 each: commit destination logical numbers.
- `rd1_enc_in`, `rd2_enc_in` in 1 each: committing instruction has a destination.
- `rob1_tag_c`, `rob2_tag_c` in ROB_W each: committing ROB tags.
- `rd1_enc`, `rd2_enc` out 1 each: combinational; committed destination is the latest mapping, so update `srat_1`.

## Operation
- Table state: `tag[NREG]` (ROB_W bits) and `live[NREG]` (1 bit).
- Source lookup (RNR): the raw value for each source is `{live, tag}` at its logical index. Intra-group bypass: if `rd1_en` and `rs2l==rd1l`, then `rs2` gets `{1, rob1_tag}`; the same rule applies to `rt2l`. Instr1 sources never bypass. Logical register 0 always yields `rob=0`, `tag=0`.
- Rename write (when `!stall_RNR && !recover`): set `tag[rd1l]<=rob1_tag` and `live<=1` if `rd1_en`; do the same for rd2. If both are enabled with `rd1l==rd2l`, instr2 wins. Writes to register 0 are ignored.
- Commit decision (combinational, uses pre-edge table):
  - `rd2_enc = rd2_enc_in && live[rd2l_c] && tag[rd2l_c]==rob2_tag_c`.
  - `rd1_enc = rd1_enc_in && live[rd1l_c] && tag[rd1l_c]==rob1_tag_c && !(rd2_enc_in && rd2l_c==rd1l_c)`.
  - Commit is independent of `stall_RNR`.
- Commit clear: on each asserted `rdN_enc`, clear `live[rdN_l_c]` at the edge, unless a same-cycle rename writes the same index. In that case the rename wins.
- Recover: at the next edge clear all `live` bits and all registered `*_rob` outputs; `*_tag` outputs go to 0. Rename writes and commit clears in that cycle are discarded, and `rdN_enc` is forced to 0.
- Stall: when `stall_RR` is set, source outputs hold their value. When `stall_RNR` is set, no rename writes occur, but sources still update unless `stall_RR` is set.

## Timing
- Reset (`rst==0` at edge): all `live=0`, `tag=0`, all source outputs 0. `rdN_enc` is 0 after reset because `live` is 0.
- Source outputs: 1-cycle latency. They reflect the table before the same-edge rename write, plus the bypass.
- `rdN_enc`: 0-cycle combinational from commit inputs.
- A rename at cycle t is visible to lookups at cycle t+1.
- Reset dominates `recover`; `recover` dominates stall.

## Structure
- Shared package `rename_pkg`: `NREG`, `ROB_W`, `logic_reg_t` (5 bits), `rob_tag_t`, and the struct `src_map_t {rob, tag}`, which is also used by the ROB and RR stage.
- One sub-module, `srat_tag_lookup`: a combinational 4-port read with the intra-group bypass and register-0 masking. The state and commit logic stay in the top.

## Test plan
- Reset then lookup with `rs1l=5`: next cycle `rs1_rob=0`, `rs1_tag=0`.
- Rename `rd1l=3`/tag 10, `rd2l=3`/tag 11, both enabled; next group with `rs1l=3` gives `rs1_rob=1`, `rs1_tag=11`.
- Same group `rd1l=7`/tag 4 with `rs2l=7` gives `rs2_rob=1`, `rs2_tag=4`. Instr1 with `rs1l=7` and an empty table gives `rs1_rob=0`.
- Map r3 to tag 11, then commit tag 10 on r3: `rd1_enc=0`. Commit tag 11: `rd1_enc=1`, and `live[3]` clears next cycle. Commit r3 tag 11 while simultaneously renaming r3 to tag 12: `rd1_enc=1`, and r3 stays live with tag 12.
- Dual commit with `rd1l_c=rd2l_c=9`, tags matching instr2: `rd1_enc=0`, `rd2_enc=1`.
- With mappings live, assert `recover` alongside a rename of r4: next cycle all lookups return `rob=0`, and r4 is not mapped.
